uart_baud_gen: RTL and testbench

Runtime-programmable fractional baud/oversample tick generator for the UART datapath; the next generation of the fixed-ratio UART clock divider. It counts a divisor loaded through a valid/ready config port, stretches individual periods by one cycle to realise a fractional average divisor, and emits `NumMarks` independently positioned single-cycle marks per period plus a period-wrap pulse. The UART TX/RX engines consume the marks: sample point, bit edge, and so on.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_frac_accum.sv | 34 +++
 rtl/uart_baud_gen.sv | 117 +++++++++++
 tb/tb_uart_baud_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, reset defaults and the configuration record for the UART
// fractional baud/oversample tick generator.
package uart_pkg;

    localparam int CNT_WIDTH        = 16;
    localparam int FRAC_WIDTH       = 4;
    localparam int NUM_MARKS        = 2;
    localparam int DEFAULT_DIV_INT  = 16;
    localparam int DEFAULT_DIV_FRAC = 0;
    localparam int DEFAULT_MARK_POS = 1;

    typedef struct packed {
        logic [CNT_WIDTH-1:0]                div_int;
        logic [FRAC_WIDTH-1:0]               div_frac;
        logic [NUM_MARKS-1:0][CNT_WIDTH-1:0] mark_pos;
    } baud_cfg_t;

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional accumulator: adds div_frac on every period wrap and turns the
// carry into a one-cycle stretch of the following period.
module uart_frac_accum
    import uart_pkg::*;
#(
    parameter int FracWidth = FRAC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 wrap_i,
    input  logic [FracWidth-1:0] frac_i,
    output logic                 extend_o
);

    logic [FracWidth-1:0] acc_r;
    logic                 extend_r;
    logic [FracWidth:0]   sum_s;

    assign sum_s    = {1'b0, acc_r} + {1'b0, frac_i};
    assign extend_o = extend_r;

    // Restart on reset/clear/config load, otherwise accumulate at each wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i || load_i) begin
            acc_r    <= {FracWidth{1'b0}};
            extend_r <= 1'b0;
        end else if (wrap_i) begin
            {extend_r, acc_r} <= sum_s;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable fractional baud tick generator with NumMarks
// independently placed mark channels and a period-wrap pulse.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CntWidth       = CNT_WIDTH,
    parameter int FracWidth      = FRAC_WIDTH,
    parameter int NumMarks       = NUM_MARKS,
    parameter int DefaultDivInt  = DEFAULT_DIV_INT,
    parameter int DefaultDivFrac = DEFAULT_DIV_FRAC,
    parameter int DefaultMarkPos = DEFAULT_MARK_POS
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic                         enable_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [CntWidth-1:0]          div_int_i,
    input  logic [FracWidth-1:0]         div_frac_i,
    input  logic [NumMarks*CntWidth-1:0] mark_pos_i,
    output logic [NumMarks-1:0]          div_mark_o,
    output logic                         period_o,
    output logic                         cfg_pending_o,
    output logic                         err_o
);

    localparam logic [NumMarks*CntWidth-1:0] MARK_RST =
        {NumMarks{CntWidth'(DefaultMarkPos)}};

    logic [CntWidth-1:0]          cnt_r;
    logic [CntWidth-1:0]          div_int_r, div_int_sh_r;
    logic [FracWidth-1:0]         div_frac_r, div_frac_sh_r;
    logic [NumMarks*CntWidth-1:0] mark_pos_r, mark_pos_sh_r;
    logic                         pending_r, err_r, period_r;
    logic [NumMarks-1:0]          mark_r, mark_hit_s;
    logic                         extend_s, hit_s, wrap_s, apply_s, xfer_s, cfg_ok_s;
    logic [CntWidth-1:0]          term_s;

    // div_int >= 2 keeps term non-negative; div_int = 2^W-1 plus extend tops out at 2^W-1.
    assign term_s   = div_int_r - CntWidth'(1) + CntWidth'(extend_s);
    assign hit_s    = enable_i && !clear_i;
    assign wrap_s   = hit_s && (cnt_r == term_s);
    assign apply_s  = pending_r && (clear_i || !enable_i || wrap_s);
    assign xfer_s   = cfg_valid_i && !pending_r;
    assign cfg_ok_s = (div_int_i >= CntWidth'(2));

    uart_frac_accum #(.FracWidth(FracWidth)) u_accum (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (clear_i),
        .load_i   (apply_s),
        .wrap_i   (wrap_s),
        .frac_i   (div_frac_r),
        .extend_o (extend_s)
    );

    for (genvar j = 0; j < NumMarks; j++) begin : g_mark
        assign mark_hit_s[j] = hit_s && (cnt_r == mark_pos_r[j*CntWidth +: CntWidth]);
    end

    // Phase counter; any restart (clear or config apply) begins a fresh period at 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (clear_i || apply_s || wrap_s) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (enable_i) begin
            cnt_r <= cnt_r + CntWidth'(1);
        end
    end

    // Config handshake, shadow capture and apply; capture and apply never coincide
    // because capture needs pending low and apply needs pending high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_int_r     <= CntWidth'(DefaultDivInt);
            div_frac_r    <= FracWidth'(DefaultDivFrac);
            mark_pos_r    <= MARK_RST;
            div_int_sh_r  <= CntWidth'(DefaultDivInt);
            div_frac_sh_r <= FracWidth'(DefaultDivFrac);
            mark_pos_sh_r <= MARK_RST;
            pending_r     <= 1'b0;
            err_r         <= 1'b0;
        end else if (apply_s) begin
            div_int_r  <= div_int_sh_r;
            div_frac_r <= div_frac_sh_r;
            mark_pos_r <= mark_pos_sh_r;
            pending_r  <= 1'b0;
        end else if (xfer_s && cfg_ok_s) begin
            div_int_sh_r  <= div_int_i;
            div_frac_sh_r <= div_frac_i;
            mark_pos_sh_r <= mark_pos_i;
            pending_r     <= 1'b1;
        end else if (xfer_s) begin
            err_r <= 1'b1;
        end
    end

    // Registered single-cycle mark and period pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mark_r   <= {NumMarks{1'b0}};
            period_r <= 1'b0;
        end else begin
            mark_r   <= mark_hit_s;
            period_r <= wrap_s;
        end
    end

    assign cfg_ready_o   = !pending_r;
    assign cfg_pending_o = pending_r;
    assign err_o         = err_r;
    assign div_mark_o    = mark_r;
    assign period_o      = period_r;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: constant vector table, directed
// multi-cycle sequences, and randomized traffic against a period-schedule model.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        reset_i, clear_i, enable_i, cfg_valid_i;
    logic        cfg_ready_o, period_o, cfg_pending_o, err_o;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic [31:0] mark_pos_i;
    logic [1:0]  div_mark_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    uart_baud_gen dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .enable_i      (enable_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .div_int_i     (div_int_i),
        .div_frac_i    (div_frac_i),
        .mark_pos_i    (mark_pos_i),
        .div_mark_o    (div_mark_o),
        .period_o      (period_o),
        .cfg_pending_o (cfg_pending_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the current period, index of the period
    // since the last restart, and period length from the closed-form fraction.
    int   m_div, m_frac, s_div, s_frac, m_pos, m_k;
    int   m_mark[2];
    int   s_mark[2];
    bit   m_pend, m_err, e_period;
    logic [1:0] e_mark;

    function automatic int plen(input int k);
        if (k == 0) return m_div;
        return m_div + (k * m_frac) / 16 - ((k - 1) * m_frac) / 16;
    endfunction

    task automatic model_edge();
        bit hit, wrap, apply, old_pend;
        int len;
        if (reset_i) begin
            m_div = 16; m_frac = 0; s_div = 16; s_frac = 0;
            m_mark[0] = 1; m_mark[1] = 1; s_mark[0] = 1; s_mark[1] = 1;
            m_pend = 0; m_err = 0; m_pos = 0; m_k = 0;
            e_mark = 2'b00; e_period = 0;
        end else begin
            hit      = enable_i && !clear_i;
            len      = plen(m_k);
            wrap     = hit && (m_pos == len - 1);
            old_pend = m_pend;
            apply    = old_pend && (clear_i || !enable_i || wrap);
            for (int j = 0; j < 2; j++) e_mark[j] = hit && (m_pos == m_mark[j]);
            e_period = wrap;
            if (apply) begin
                m_div = s_div; m_frac = s_frac;
                m_mark[0] = s_mark[0]; m_mark[1] = s_mark[1];
                m_pend = 0;
            end
            if (apply || clear_i) begin
                m_pos = 0; m_k = 0;
            end else if (hit) begin
                if (wrap) begin m_pos = 0; m_k++; end
                else m_pos++;
            end
            if (cfg_valid_i && !old_pend) begin
                if (div_int_i >= 16'd2) begin
                    s_div = int'(div_int_i); s_frac = int'(div_frac_i);
                    s_mark[0] = int'(mark_pos_i[15:0]); s_mark[1] = int'(mark_pos_i[31:16]);
                    m_pend = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    function automatic logic [5:0] outs();
        return {div_mark_o, period_o, cfg_ready_o, cfg_pending_o, err_o};
    endfunction

    task automatic step();
        logic [5:0] exp;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        exp = {e_mark, e_period, !m_pend, m_pend, m_err};
        tests++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL model cyc=%0d got=%b exp=%b", cyc, outs(), exp);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        reset_i = 0; clear_i = 0; enable_i = 0; cfg_valid_i = 0;
        div_int_i = 16'd0; div_frac_i = 4'd0; mark_pos_i = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1;
        step();
        step();
        reset_i = 0;
        check("reset_state", int'(outs()), int'(6'b000100));
    endtask

    task automatic offer(input int di, input int df, input int m0, input int m1);
        cfg_valid_i = 1; div_int_i = 16'(di); div_frac_i = 4'(df);
        mark_pos_i = {16'(m1), 16'(m0)};
        step();
        cfg_valid_i = 0;
    endtask

    // Steps until period_o is seen; returns the step count, or -1 on budget expiry.
    task automatic wait_period(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (period_o) begin n = i; break; end
        end
    endtask

    typedef struct {
        bit          clr;
        bit          en;
        bit          vld;
        logic [15:0] di;
        logic [3:0]  df;
        logic [31:0] mp;
        logic [5:0]  exp;
    } vec_t;

    vec_t vt[15];
    int   n, total, marks, pers;

    initial begin
        // {mark1, mark0, period, ready, pending, err} after each edge
        vt[0]  = '{0, 0, 0, 16'd0, 4'd0, 32'h0, 6'b000100};
        vt[1]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000100};
        vt[2]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b110100};
        vt[3]  = '{0, 1, 1, 16'd1, 4'd0, 32'h0, 6'b000101};
        vt[4]  = '{0, 1, 1, 16'd5, 4'd0, 32'h0003_0001, 6'b000011};
        vt[5]  = '{0, 0, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[6]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[7]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b010101};
        vt[8]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[9]  = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b100101};
        vt[10] = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b001101};
        vt[11] = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[12] = '{1, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[13] = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b000101};
        vt[14] = '{0, 1, 0, 16'd0, 4'd0, 32'h0, 6'b010101};

        do_reset();
        foreach (vt[i]) begin
            clear_i = vt[i].clr; enable_i = vt[i].en; cfg_valid_i = vt[i].vld;
            div_int_i = vt[i].di; div_frac_i = vt[i].df; mark_pos_i = vt[i].mp;
            step();
            check($sformatf("vec%0d", i), int'(outs()), int'(vt[i].exp));
        end
        idle_inputs();

        // Defaults: 16-cycle period, both marks two edges after enable rises.
        do_reset();
        enable_i = 1;
        step();
        step();
        check("first_mark", int'(div_mark_o), 3);
        wait_period(40, n);
        check("default_first_period", n, 14);
        wait_period(40, n);
        check("default_period", n, 16);

        // Mid-period reconfiguration to 20; a second offer while pending is ignored.
        do_reset();
        enable_i = 1;
        for (int i = 0; i < 5; i++) step();
        offer(20, 0, 1, 1);
        check("pending_after_offer", int'(cfg_pending_o), 1);
        offer(30, 0, 1, 1);
        check("ready_low_while_pending", int'(cfg_ready_o), 0);
        wait_period(40, n);
        check("old_period_finishes", n + 7, 16);
        check("pending_cleared_on_wrap", int'(cfg_pending_o), 0);
        wait_period(40, n);
        check("new_period_20", n, 20);
        wait_period(40, n);
        check("second_offer_dropped", n, 20);

        // Rejected divisor: sticky error, no pending, period unchanged.
        do_reset();
        enable_i = 1;
        offer(1, 0, 1, 1);
        check("err_set", int'(err_o), 1);
        check("no_pending_on_err", int'(cfg_pending_o), 0);
        wait_period(40, n);
        wait_period(40, n);
        check("period_after_err", n, 16);
        check("err_sticky", int'(err_o), 1);

        // Fractional divisor 10.5: 32 periods span exactly 336 cycles.
        do_reset();
        enable_i = 1;
        offer(10, 8, 1, 1);
        clear_i = 1; step(); clear_i = 0;
        wait_period(40, n);
        total = 0;
        for (int p = 0; p < 32; p++) begin
            wait_period(40, n);
            total += (n < 0) ? 1000 : n;
        end
        check("frac_32_periods", total, 336);

        // Clear at cnt=7, then 5 frozen cycles, then a full 16-cycle period.
        do_reset();
        enable_i = 1;
        for (int i = 0; i < 7; i++) step();
        clear_i = 1; step(); clear_i = 0;
        check("clear_no_period", int'(period_o), 0);
        enable_i = 0;
        marks = 0;
        for (int i = 0; i < 5; i++) begin step(); marks += int'(div_mark_o != 2'b00); end
        check("frozen_no_marks", marks, 0);
        enable_i = 1;
        wait_period(40, n);
        check("period_after_clear", n, 16);

        // Mark position beyond the terminal count never fires.
        do_reset();
        enable_i = 1;
        offer(16, 0, 20, 20);
        clear_i = 1; step(); clear_i = 0;
        marks = 0; pers = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            marks += int'(div_mark_o != 2'b00);
            pers  += int'(period_o);
        end
        check("mark_beyond_term", marks, 0);
        check("periods_in_48", pers, 3);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_i     = ($urandom_range(0, 399) == 0);
            clear_i     = ($urandom_range(0, 39) == 0);
            enable_i    = ($urandom_range(0, 7) != 0);
            cfg_valid_i = ($urandom_range(0, 7) == 0);
            div_int_i   = 16'($urandom_range(0, 24));
            div_frac_i  = 4'($urandom_range(0, 15));
            mark_pos_i  = {16'($urandom_range(0, 24)), 16'($urandom_range(0, 24))};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
